sram_spi_ctrl: RTL and testbench
================================

# sram_spi_ctrl

Command sequencer between the byte-level SPI slave shim and the on-chip SRAM array. It decodes the instruction and address bytes the host clocks in, issues SRAM read/write strobes with an auto-incrementing address, and loads reply bytes for the shifter. Protocol subset: READ, WRITE, RDSR and WRSR, with byte and sequential access modes. The whole block runs in the SPI clock domain.

## Interface
Parameters:
- ADDR_W, 8, SRAM address width; one address byte per transaction (ADDR_W ≤ 8).
- DATA_W, 8, SRAM word width; fixed equal to the SPI byte.

Ports:
- sck  in  1  SPI clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- cs  in  1  chip select, active low, sampled on sck.
- rx_byte  in  8  byte just assembled by the shifter.
- rx_valid  in  1  one-sck pulse: rx_byte is complete.
- tx_byte  out  8  reply byte for the shifter.
- tx_load  out  1  one-sck pulse: shifter loads tx_byte.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  8  SRAM write data.
- sram_we  out  1  write strobe, one sck.
- sram_re  out  1  read strobe, one sck; sram_rdata is valid on the next sck edge.
- sram_rdata  in  8  SRAM read data.
- status  out  8  mode register {mode[1:0], 6'b0}.
- active  out  1  state ≠ IDLE.

## Operation
- Opcodes: 0x03 READ, 0x02 WRITE, 0x05 RDSR, 0x01 WRSR. Any other value is illegal.
- States and transitions:
  - IDLE: first rx_valid with cs=0 → CMD decode.
  - CMD: READ/WRITE → ADDR; RDSR → STAT_RD; WRSR → STAT_WR; illegal → IGNORE.
  - ADDR: next rx_valid latches the address, then → RDATA (READ) or WDATA (WRITE).
  - WDATA: each rx_valid issues one SRAM write.
  - RDATA: each reply byte is fetched from SRAM.
  - STAT_RD: status is loaded as the reply.
  - STAT_WR: next rx_valid writes rx_byte[7:6] into mode, then → DONE.
  - DONE, IGNORE: ignore rx_valid until cs=1.
- cs=1 at any sck edge → IDLE next edge; partial bytes are dropped; address and mode are kept.
- mode: 00 byte, 01 sequential (reset value), 1x reserved and treated as sequential.
- Byte mode: after one data byte in WDATA or RDATA → DONE.
- Sequential mode: address +1 after every access, wrapping from 2^ADDR_W−1 to 0.
- WRSR ignores rx_byte[5:0]; status[5:0] always reads 0.

## Timing
- Reset values: tx_byte=0, tx_load=0, sram_addr=0, sram_wdata=0, sram_we=0, sram_re=0, status=8'h40, active=0, state IDLE.
- Reset mid-transaction aborts with no further strobes; a write that is pending but not yet strobed is lost.
- Write path:
  - rx_valid at edge N in WDATA → at N+1, sram_we=1, sram_addr=current, sram_wdata=rx_byte.
  - Address increments at N+1.
- Read path:
  - Address byte accepted at edge N → sram_re=1 at N+1.
  - tx_byte=sram_rdata and tx_load=1 at N+2.
  - In sequential mode, each later rx_valid (a host dummy byte) at edge M → sram_re at M+1 for the incremented address, tx_load at M+2.
  - The shifter's 8-sck byte period covers this 2-cycle latency.
- RDSR: rx_valid of the opcode at N → tx_byte=status, tx_load=1 at N+1.
- rx_valid together with cs=1 is ignored; cs wins.
- sram_we and sram_re are never asserted in the same cycle and never outside WDATA/RDATA.

## Structure
- Shared package sram_spi_pkg holds:
  - Opcode constants OP_READ, OP_WRITE, OP_RDSR, OP_WRSR.
  - State encoding (3-bit enum).
  - Mode constants MODE_BYTE and MODE_SEQ.
  - STATUS_RST = 8'h40.
- One optional sub-module, sram_spi_addr_ctr: loadable, wrapping address counter with an increment enable.
- Everything else stays in a single always block for the FSM plus output registers.

## Test plan
- WRITE sequential: bytes 0x02, 0x10, 0xAA, 0xBB → sram_we at addr 0x10 with 0xAA, then addr 0x11 with 0xBB; raising cs → IDLE.
- READ sequential at 0xFF: memory[0xFF]=0x5A and memory[0x00]=0xA5; send 0x03, 0xFF, dummy → tx_byte 0x5A then 0xA5 (wrap), each 2 sck after its trigger.
- WRSR 0x00 then WRITE 0x02, 0x20, 0x11, 0x22 → only addr 0x20 written with 0x11; RDSR returns tx_byte=0x00.
- Illegal opcode 0x9C followed by 0x02, 0x30, 0x44 → no sram_we and no tx_load until cs toggles.
- cs raised mid-address byte, then a new transaction 0x05 → tx_byte=0x40; sram_we and sram_re stay 0 throughout.
- rst asserted the cycle after a WRITE data rx_valid → no sram_we; all outputs at reset values; status=0x40.

Source files
------------

// File: rtl/sram_spi_pkg.sv
// Shared constants and state encoding for the SPI-to-SRAM command sequencer.
package sram_spi_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned MODE_W = 2;

  localparam logic [BYTE_W-1:0] OP_READ  = 8'h03;
  localparam logic [BYTE_W-1:0] OP_WRITE = 8'h02;
  localparam logic [BYTE_W-1:0] OP_RDSR  = 8'h05;
  localparam logic [BYTE_W-1:0] OP_WRSR  = 8'h01;

  localparam logic [MODE_W-1:0] MODE_BYTE = 2'b00;
  localparam logic [MODE_W-1:0] MODE_SEQ  = 2'b01;

  localparam logic [BYTE_W-1:0] STATUS_RST = 8'h40;

  // Opcode decode happens on the opcode byte in IDLE, so no separate CMD state.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_STAT_RD,
    ST_STAT_WR,
    ST_DONE,
    ST_IGNORE
  } state_t;

  // Reserved modes 1x behave as sequential.
  function automatic logic is_seq(input logic [MODE_W-1:0] mode);
    return mode != MODE_BYTE;
  endfunction

endpackage

// File: rtl/sram_spi_addr_ctr.sv
// Loadable SRAM address counter; wraps naturally at 2^ADDR_W.
module sram_spi_addr_ctr #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_val;
    end else if (inc) begin
      addr <= addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/sram_spi_ctrl.sv
// SPI command sequencer: decodes READ/WRITE/RDSR/WRSR and drives SRAM strobes.
module sram_spi_ctrl
  import sram_spi_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              sck,
  input  logic              rst,
  input  logic              cs,
  input  logic [DATA_W-1:0] rx_byte,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_byte,
  output logic              tx_load,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_we,
  output logic              sram_re,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [7:0]        status,
  output logic              active
);

  state_t              state, state_nxt;
  logic [MODE_W-1:0]   mode, mode_nxt;
  logic                is_read, is_read_nxt;
  logic [DATA_W-1:0]   tx_byte_nxt, wdata_nxt;
  logic                tx_load_nxt, we_nxt, re_nxt;
  logic                addr_load, addr_inc;

  // Address advances on the cycle after each strobe, so the strobe sees the current address.
  assign addr_inc = (sram_we | sram_re) & is_seq(mode);
  assign status   = {mode, 6'b0};

  sram_spi_addr_ctr #(.ADDR_W(ADDR_W)) u_addr_ctr (
    .clk      (sck),
    .rst_n    (rst),
    .load     (addr_load),
    .load_val (rx_byte[ADDR_W-1:0]),
    .inc      (addr_inc),
    .addr     (sram_addr)
  );

  always_comb begin
    state_nxt   = state;
    mode_nxt    = mode;
    is_read_nxt = is_read;
    tx_byte_nxt = tx_byte;
    tx_load_nxt = 1'b0;
    wdata_nxt   = sram_wdata;
    we_nxt      = 1'b0;
    re_nxt      = 1'b0;
    addr_load   = 1'b0;

    if (cs) begin
      state_nxt = ST_IDLE;
    end else begin
      // Read data returns one cycle after the strobe and goes straight to the shifter.
      if (sram_re) begin
        tx_byte_nxt = sram_rdata;
        tx_load_nxt = 1'b1;
      end
      if (rx_valid) begin
        case (state)
          ST_IDLE: begin
            case (rx_byte)
              OP_READ: begin
                state_nxt   = ST_ADDR;
                is_read_nxt = 1'b1;
              end
              OP_WRITE: begin
                state_nxt   = ST_ADDR;
                is_read_nxt = 1'b0;
              end
              OP_RDSR: begin
                state_nxt   = ST_STAT_RD;
                tx_byte_nxt = status;
                tx_load_nxt = 1'b1;
              end
              OP_WRSR: state_nxt = ST_STAT_WR;
              default: state_nxt = ST_IGNORE;
            endcase
          end
          ST_ADDR: begin
            addr_load = 1'b1;
            if (is_read) begin
              state_nxt = ST_RDATA;
              re_nxt    = 1'b1;
            end else begin
              state_nxt = ST_WDATA;
            end
          end
          ST_WDATA: begin
            we_nxt    = 1'b1;
            wdata_nxt = rx_byte;
            if (!is_seq(mode)) state_nxt = ST_DONE;
          end
          ST_RDATA: begin
            // First byte was prefetched on the address; each dummy byte prefetches the next.
            if (is_seq(mode)) re_nxt = 1'b1;
            else              state_nxt = ST_DONE;
          end
          ST_STAT_RD: begin
            tx_byte_nxt = status;
            tx_load_nxt = 1'b1;
          end
          ST_STAT_WR: begin
            mode_nxt  = rx_byte[7:6];
            state_nxt = ST_DONE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge sck or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      mode       <= MODE_SEQ;
      is_read    <= 1'b0;
      tx_byte    <= '0;
      tx_load    <= 1'b0;
      sram_wdata <= '0;
      sram_we    <= 1'b0;
      sram_re    <= 1'b0;
      active     <= 1'b0;
    end else begin
      state      <= state_nxt;
      mode       <= mode_nxt;
      is_read    <= is_read_nxt;
      tx_byte    <= tx_byte_nxt;
      tx_load    <= tx_load_nxt;
      sram_wdata <= wdata_nxt;
      sram_we    <= we_nxt;
      sram_re    <= re_nxt;
      active     <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_sram_spi_ctrl.sv
// Directed bench for sram_spi_ctrl with a behavioural SRAM and strobe counters.
module tb_sram_spi_ctrl;

  logic       sck;
  logic       rst;
  logic       cs;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] tx_byte;
  logic       tx_load;
  logic [7:0] sram_addr;
  logic [7:0] sram_wdata;
  logic       sram_we;
  logic       sram_re;
  logic [7:0] sram_rdata;
  logic [7:0] status;
  logic       active;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int re_cnt = 0;
  int ld_cnt = 0;
  int w0, r0, l0;

  logic [7:0] mem [256];

  sram_spi_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
    .sck        (sck),
    .rst        (rst),
    .cs         (cs),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .tx_byte    (tx_byte),
    .tx_load    (tx_load),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_we    (sram_we),
    .sram_re    (sram_re),
    .sram_rdata (sram_rdata),
    .status     (status),
    .active     (active)
  );

  initial sck = 1'b0;
  always #5 sck = ~sck;

  // Asynchronous-read SRAM: data for the strobed address is ready at the next edge.
  assign sram_rdata = mem[sram_addr];

  always @(posedge sck) begin
    if (sram_we) mem[sram_addr] <= sram_wdata;
    if (sram_we) we_cnt++;
    if (sram_re) re_cnt++;
    if (tx_load) ld_cnt++;
    if (rst) begin
      assert (!(sram_we && sram_re)) else begin
        errors++;
        $error("FAIL we_re_overlap observed=1 expected=0");
      end
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs at the falling edge; return just after the rising edge that samples them.
  task automatic step(input logic c, input logic v, input logic [7:0] b);
    @(negedge sck);
    cs = c; rx_valid = v; rx_byte = b;
    @(posedge sck);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx_byte"}, tx_byte, 8'h00);
    chk({tag, "_tx_load"}, 8'(tx_load), 8'h00);
    chk({tag, "_addr"}, sram_addr, 8'h00);
    chk({tag, "_wdata"}, sram_wdata, 8'h00);
    chk({tag, "_we"}, 8'(sram_we), 8'h00);
    chk({tag, "_re"}, 8'(sram_re), 8'h00);
    chk({tag, "_status"}, status, 8'h40);
    chk({tag, "_active"}, 8'(active), 8'h00);
  endtask

  initial begin
    rst = 1'b0; cs = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
    repeat (2) @(posedge sck);
    #1;
    chk_reset_outputs("rst0");
    @(negedge sck);
    rst = 1'b1;

    // Sequential WRITE at 0x10
    step(1'b0, 1'b1, 8'h02);
    chk("wr_active", 8'(active), 8'h01);
    step(1'b0, 1'b1, 8'h10);
    chk("wr_addr_no_we", 8'(sram_we), 8'h00);
    step(1'b0, 1'b1, 8'hAA);
    chk("wr0_we", 8'(sram_we), 8'h01);
    chk("wr0_addr", sram_addr, 8'h10);
    chk("wr0_data", sram_wdata, 8'hAA);
    step(1'b0, 1'b0, 8'h00);
    chk("wr_inc_addr", sram_addr, 8'h11);
    chk("wr_we_pulse", 8'(sram_we), 8'h00);
    step(1'b0, 1'b1, 8'hBB);
    chk("wr1_we", 8'(sram_we), 8'h01);
    chk("wr1_addr", sram_addr, 8'h11);
    chk("wr1_data", sram_wdata, 8'hBB);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    chk("wr_cs_idle", 8'(active), 8'h00);
    chk("mem10", mem[8'h10], 8'hAA);
    chk("mem11", mem[8'h11], 8'hBB);

    // Preload 0xFF and 0x00 through a wrapping sequential WRITE
    step(1'b0, 1'b1, 8'h02);
    step(1'b0, 1'b1, 8'hFF);
    step(1'b0, 1'b1, 8'h5A);
    step(1'b0, 1'b0, 8'h00);
    chk("wr_wrap_addr", sram_addr, 8'h00);
    step(1'b0, 1'b1, 8'hA5);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    chk("memFF", mem[8'hFF], 8'h5A);
    chk("mem00", mem[8'h00], 8'hA5);

    // Sequential READ at 0xFF with wrap
    step(1'b0, 1'b1, 8'h03);
    step(1'b0, 1'b1, 8'hFF);
    chk("rd0_re", 8'(sram_re), 8'h01);
    chk("rd0_addr", sram_addr, 8'hFF);
    chk("rd0_no_load_yet", 8'(tx_load), 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("rd0_load", 8'(tx_load), 8'h01);
    chk("rd0_tx", tx_byte, 8'h5A);
    chk("rd0_re_pulse", 8'(sram_re), 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("rd0_load_pulse", 8'(tx_load), 8'h00);
    step(1'b0, 1'b1, 8'h00);
    chk("rd1_re", 8'(sram_re), 8'h01);
    chk("rd1_addr", sram_addr, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("rd1_load", 8'(tx_load), 8'h01);
    chk("rd1_tx", tx_byte, 8'hA5);
    step(1'b1, 1'b0, 8'h00);

    // WRSR to byte mode, then a multi-byte WRITE writes only once
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b1, 8'h3F);
    chk("wrsr_byte_status", status, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    w0 = we_cnt;
    step(1'b0, 1'b1, 8'h02);
    step(1'b0, 1'b1, 8'h20);
    step(1'b0, 1'b1, 8'h11);
    chk("bm_we", 8'(sram_we), 8'h01);
    chk("bm_addr", sram_addr, 8'h20);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h22);
    chk("bm_second_no_we", 8'(sram_we), 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    chk("bm_we_count", 8'(we_cnt - w0), 8'h01);
    chk("mem20", mem[8'h20], 8'h11);
    step(1'b0, 1'b1, 8'h05);
    chk("rdsr_byte_load", 8'(tx_load), 8'h01);
    chk("rdsr_byte_tx", tx_byte, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b1, 8'h40);
    chk("wrsr_seq_status", status, 8'h40);
    step(1'b1, 1'b0, 8'h00);

    // Illegal opcode swallows the rest of the transaction
    w0 = we_cnt; l0 = ld_cnt;
    step(1'b0, 1'b1, 8'h9C);
    step(1'b0, 1'b1, 8'h02);
    step(1'b0, 1'b1, 8'h30);
    step(1'b0, 1'b1, 8'h44);
    step(1'b0, 1'b0, 8'h00);
    chk("ill_active", 8'(active), 8'h01);
    chk("ill_we_count", 8'(we_cnt - w0), 8'h00);
    chk("ill_ld_count", 8'(ld_cnt - l0), 8'h00);
    step(1'b1, 1'b0, 8'h00);
    chk("ill_cs_idle", 8'(active), 8'h00);

    // cs raised mid-address, rx_valid under cs=1, then RDSR
    w0 = we_cnt; r0 = re_cnt; l0 = ld_cnt;
    step(1'b0, 1'b1, 8'h03);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    chk("abort_idle", 8'(active), 8'h00);
    step(1'b1, 1'b1, 8'h05);
    chk("cs_wins_active", 8'(active), 8'h00);
    chk("cs_wins_load", 8'(tx_load), 8'h00);
    step(1'b0, 1'b1, 8'h05);
    chk("rdsr_load", 8'(tx_load), 8'h01);
    chk("rdsr_tx", tx_byte, 8'h40);
    step(1'b1, 1'b0, 8'h00);
    chk("abort_we_count", 8'(we_cnt - w0), 8'h00);
    chk("abort_re_count", 8'(re_cnt - r0), 8'h00);
    chk("abort_ld_count", 8'(ld_cnt - l0), 8'h01);

    // Reset lands while a write strobe is pending
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b1, 8'hC0);
    chk("wrsr_rsvd_status", status, 8'hC0);
    step(1'b1, 1'b0, 8'h00);
    w0 = we_cnt;
    step(1'b0, 1'b1, 8'h02);
    step(1'b0, 1'b1, 8'h50);
    step(1'b0, 1'b1, 8'h77);
    chk("pend_we", 8'(sram_we), 8'h01);
    #1;
    rst = 1'b0;
    #1;
    chk_reset_outputs("rst1");
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    @(negedge sck);
    rst = 1'b1;
    step(1'b1, 1'b0, 8'h00);
    chk("rst_we_count", 8'(we_cnt - w0), 8'h00);
    chk("rst_status_hold", status, 8'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
